// File: rtl/ext_irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package ext_irq_pkg;

    typedef logic [1:0] irq_state_t;

    localparam irq_state_t IDLE    = 2'd0;
    localparam irq_state_t REQ     = 2'd1;
    localparam irq_state_t SERVICE = 2'd2;

    localparam int EXT_IRQ_MAX_LINES = 16;

endpackage

// File: rtl/ext_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder (module irq_prio_enc), purely combinational.
module irq_prio_enc #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_IRQ-1:0] cand,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |cand;
        // Walk downwards so the lowest set index is written last.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: sticky pending/lost bits and one req/ack/eoi handshake.
// Optional EXT_IRQ_SYNC_EN inserts a two-flop synchroniser in front of rise capture.
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    input  logic             lost_clr,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] irq_lost
);

    irq_state_t       state;
    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] clr_mask;
    logic [ID_W-1:0]  win_id;
    logic             win_valid;
    logic             ack_ok;

`ifdef EXT_IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq_in;
`endif

    // Long detector pulses (divided clock) collapse to a single rise here.
    assign rise     = irq_s & ~irq_prev;
    assign ack_ok   = (state == REQ) && irq_ack;
    assign clr_mask = ack_ok ? (N_IRQ'(1) << irq_id) : '0;
    assign cand     = pending & irq_en;

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .cand  (cand),
        .idx   (win_id),
        .valid (win_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
            irq_lost <= '0;
        end else begin
            irq_prev <= irq_s;
            pending  <= (pending & ~clr_mask) | rise;
            irq_lost <= (irq_lost & ~{N_IRQ{lost_clr}}) | (rise & pending & ~clr_mask);
        end
    end

    // irq_id is only loaded on IDLE->REQ, so it stays frozen through REQ and SERVICE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state  <= REQ;
                        irq_id <= win_id;
                    end
                end
                REQ: begin
                    if (irq_ack)              state <= SERVICE;
                    else if (!irq_en[irq_id]) state <= IDLE;
                end
                SERVICE: begin
                    if (irq_eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq_req    = (state == REQ);
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl (N_IRQ=4).
module tb_ext_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] irq_en;
    logic       irq_ack;
    logic       irq_eoi;
    logic       lost_clr;
    logic       irq_req;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] irq_lost;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    logic req_q = 1'b0;

    ext_irq_ctrl #(.N_IRQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq_en     (irq_en),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .lost_clr   (lost_clr),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .irq_lost   (irq_lost)
    );

    always #5 clk = ~clk;

    // Counts rising edges of irq_req to detect duplicate requests.
    always @(posedge clk) begin
        req_q <= irq_req;
        if (irq_req && !req_q) req_rises <= req_rises + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; irq_en = '0; irq_ack = 0; irq_eoi = 0; lost_clr = 0;
        #3;
        checks++; if ({irq_req, in_service, irq_id, pending, irq_lost} !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %b required 0", {irq_req, in_service, irq_id, pending, irq_lost}); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b required 0", irq_req); end
    endtask

    task automatic test_single_pulse();
        int base;
        base = req_rises;
        irq_en = 4'hF;
        irq_in = 4'b0100;
        tick();
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b required 0100", pending); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b required 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL single_req: got req=%b id=%0d required req=1 id=2", irq_req, irq_id); end
        tick();
        irq_ack = 1; tick(); irq_ack = 0;
        checks++; if (pending !== 4'b0000 || in_service !== 1'b1 || irq_req !== 1'b0) begin errors++; $display("FAIL single_ack: got pend=%b svc=%b req=%b required 0000 1 0", pending, in_service, irq_req); end
        tick(); tick();
        irq_in = 4'b0000;
        irq_eoi = 1; tick(); irq_eoi = 0;
        checks++; if (in_service !== 1'b0 || irq_req !== 1'b0) begin errors++; $display("FAIL single_eoi: got svc=%b req=%b required 0 0", in_service, irq_req); end
        tick(); tick();
        checks++; if (req_rises - base !== 1) begin errors++; $display("FAIL single_req_count: got %0d required 1", req_rises - base); end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010; tick(); irq_in = 4'b0000;
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending: got %b required 1010", pending); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL prio_first: got req=%b id=%0d required req=1 id=1", irq_req, irq_id); end
        irq_ack = 1; tick(); irq_ack = 0;
        checks++; if (pending !== 4'b1000 || in_service !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL prio_svc: got pend=%b svc=%b id=%0d required 1000 1 1", pending, in_service, irq_id); end
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_no_nest: got req=%b required 0", irq_req); end
        irq_eoi = 1; tick(); irq_eoi = 0;
        checks++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL prio_gap: got req=%b svc=%b required 0 0", irq_req, in_service); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd3) begin errors++; $display("FAIL prio_second: got req=%b id=%0d required req=1 id=3", irq_req, irq_id); end
        irq_ack = 1; tick(); irq_ack = 0;
        irq_eoi = 1; tick(); irq_eoi = 0;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_drain: got %b required 0000", pending); end
    endtask

    task automatic test_masking();
        irq_en = 4'b1110;
        irq_in = 4'b0001; tick(); irq_in = 4'b0000;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pending: got %b required 0001", pending); end
        tick(); tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_no_req: got %b required 0", irq_req); end
        irq_en = 4'b1111; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL mask_enable_req: got req=%b id=%0d required req=1 id=0", irq_req, irq_id); end
        irq_en = 4'b1110; tick();
        checks++; if (irq_req !== 1'b0 || pending !== 4'b0001) begin errors++; $display("FAIL mask_withdraw: got req=%b pend=%b required 0 0001", irq_req, pending); end
        irq_en = 4'b1111; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL mask_rereq: got req=%b id=%0d required req=1 id=0", irq_req, irq_id); end
        irq_ack = 1; tick(); irq_ack = 0;
        irq_eoi = 1; tick(); irq_eoi = 0;
    endtask

    task automatic test_lost();
        irq_in = 4'b0100; tick(); irq_in = 4'b0000; tick();
        irq_in = 4'b0100; tick(); irq_in = 4'b0000;
        checks++; if (irq_lost !== 4'b0100) begin errors++; $display("FAIL lost_set: got %b required 0100", irq_lost); end
        lost_clr = 1; tick(); lost_clr = 0;
        checks++; if (irq_lost !== 4'b0000) begin errors++; $display("FAIL lost_clr: got %b required 0000", irq_lost); end
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL lost_req: got req=%b id=%0d required req=1 id=2", irq_req, irq_id); end
        irq_in = 4'b0100; irq_ack = 1; tick(); irq_in = 4'b0000; irq_ack = 0;
        checks++; if (pending !== 4'b0100 || irq_lost !== 4'b0000 || in_service !== 1'b1) begin errors++; $display("FAIL lost_ack_collide: got pend=%b lost=%b svc=%b required 0100 0000 1", pending, irq_lost, in_service); end
        irq_eoi = 1; tick(); irq_eoi = 0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL lost_rereq: got req=%b id=%0d required req=1 id=2", irq_req, irq_id); end
        irq_ack = 1; tick(); irq_ack = 0;
        irq_eoi = 1; tick(); irq_eoi = 0;
    endtask

    task automatic test_reset_mid();
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick();
        irq_in = 4'b1010; irq_ack = 1; tick(); irq_in = 4'b0000; irq_ack = 0;
        checks++; if (in_service !== 1'b1 || pending !== 4'b1010) begin errors++; $display("FAIL rstmid_setup: got svc=%b pend=%b required 1 1010", in_service, pending); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({irq_req, in_service, irq_id, pending, irq_lost} !== 11'd0) begin errors++; $display("FAIL rstmid_async: got %b required 0", {irq_req, in_service, irq_id, pending, irq_lost}); end
        #2 rst = 1'b0;
        tick(); tick();
        checks++; if (irq_req !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL rstmid_after: got req=%b pend=%b required 0 0000", irq_req, pending); end
    endtask

`ifdef EXT_IRQ_SYNC_EN
    task automatic test_sync();
        irq_in = 4'b0010; tick(); irq_in = 4'b0000;
        tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL sync_early: got %b required 0000", pending); end
        tick();
        checks++; if (pending !== 4'b0010 || irq_req !== 1'b0) begin errors++; $display("FAIL sync_pending: got pend=%b req=%b required 0010 0", pending, irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL sync_req: got req=%b id=%0d required req=1 id=1", irq_req, irq_id); end
        irq_ack = 1; tick(); irq_ack = 0;
        irq_eoi = 1; tick(); irq_eoi = 0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef EXT_IRQ_SYNC_EN
        irq_en = 4'hF;
        test_sync();
`else
        test_single_pulse();
        test_priority();
        test_masking();
        test_lost();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_irq_ctrl.md
# ext_irq_ctrl

Collects the edge pulses produced by the per-line edge detectors and runs one interrupt request/acknowledge/end-of-interrupt handshake towards the CPU core. Each line has a sticky pending bit and a per-line enable. The lowest-numbered enabled pending line is presented, and only one interrupt is in service at a time. The block sits directly downstream of the edge detectors, in the fast clock domain.

## Interface
- `N_IRQ`, default 4: number of interrupt lines, 2..16.
- `ID_W`, default 2: width of the line index; must equal clog2(N_IRQ).

- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `irq_in`  in  N_IRQ: edge pulses from the edge detectors. A pulse may stay high for many `clk` cycles because the detectors run on the divided clock.
- `irq_en`  in  N_IRQ: per-line enable, quasi-static.
- `irq_ack`  in  1: core accepts the presented interrupt; single-cycle pulse.
- `irq_eoi`  in  1: core finished the handler; single-cycle pulse.
- `lost_clr`  in  1: clears `irq_lost`.
- `irq_req`  out  1: an interrupt is being presented.
- `irq_id`  out  ID_W: index of the presented or in-service line.
- `in_service`  out  1: handler is running.
- `pending`  out  N_IRQ: pending bits.
- `irq_lost`  out  N_IRQ: sticky flag per line, set when an event arrives on a line that is already pending.

## Operation
- Rise capture:
  - Register `irq_prev` holds the last sample of `irq_in` (or of the synchronised input when `EXT_IRQ_SYNC_EN` is defined).
  - `rise = in & ~irq_prev`. A long pulse produces exactly one rise.
- Pending update on each edge: `pending <= (pending & ~clr_mask) | rise`.
  - `clr_mask` is the one-hot of `irq_id` when `irq_ack` is accepted in REQ, otherwise 0.
  - If set and clear hit the same bit together, set wins and the bit stays 1.
- Lost flag:
  - `irq_lost[i] <= 1` when `rise[i]` and `pending[i]` are both 1 and bit i is not being cleared in that cycle.
  - `lost_clr` clears all lost bits. If a set happens in the same cycle, set wins.
- Masking:
  - Disabled lines still latch pending and lost.
  - A disabled line is never requested.
- Arbitration: `cand = pending & irq_en`. Winner is the lowest set index of `cand`.
- FSM states:
  - IDLE → REQ when `cand != 0`. `irq_id` is loaded with the winner.
  - REQ: `irq_req=1` and `irq_id` stays frozen.
    - On `irq_ack`: clear `pending[irq_id]`, go to SERVICE.
    - If `irq_en[irq_id]` drops before the ack: go to IDLE and leave pending untouched.
  - SERVICE: `in_service=1`, `irq_id` is held. On `irq_eoi` → IDLE.
  - `irq_ack` outside REQ and `irq_eoi` outside SERVICE are ignored.
- No nesting: a higher-priority pending line waits until EOI.
- Reset values: state IDLE; `irq_req`, `in_service`, `irq_id`, `pending`, `irq_lost`, `irq_prev` and the sync flops all 0.
- Reset asserted mid-handshake discards all pending and service state.

## Timing
- Rise sampled at edge k → `pending[i]=1` after edge k.
- `irq_req` and `irq_id` are registered and valid after edge k+1, which is the minimum latency.
- Ack sampled at edge m → `irq_req=0`, `in_service=1` and the pending bit cleared, all after edge m.
- EOI at edge n → IDLE after edge n.
- The next request, if `cand != 0`, appears after edge n+1.
- Worst case back-to-back service: 1 idle cycle between EOI and the next `irq_req`.

## Configuration
- `EXT_IRQ_SYNC_EN` defined: a two-flop synchroniser is inserted on each `irq_in` bit before rise capture. This adds 2 cycles; pending is set after edge k+2.
- `EXT_IRQ_SYNC_EN` undefined: `irq_in` goes directly into rise capture. It must already be synchronous to `clk`.

## Structure
- Shared package `ext_irq_pkg`:
  - FSM state typedef: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - Constant `EXT_IRQ_MAX_LINES=16`.
- One sub-module, `irq_prio_enc`: combinational lowest-index-first encoder producing the index and a `valid` flag, parameterised by N_IRQ and ID_W.

## Test plan
- Pulse `irq_in[2]` high for 6 cycles with `irq_en=4'hF`, no SYNC → `pending=4'b0100` after 1 edge and `irq_req=1`, `irq_id=2` after 2 edges. Ack → `pending=0`, `in_service=1`. EOI → IDLE. Only one request in total.
- Rise on lines 3 and 1 in the same cycle → `irq_id=1` served first. After EOI, `irq_id=3` is requested 1 cycle later.
- `irq_en=4'b1110` with a pulse on line 0 → `pending[0]=1`, `irq_req` stays 0. Set `irq_en[0]=1` → request with `irq_id=0`.
- Second rise on line 2 while `pending[2]=1` → `irq_lost=4'b0100`. `lost_clr` → 0. A rise on line 2 in the same cycle as its ack → `pending[2]` stays 1 and `irq_lost` stays 0.
- Assert `rst` during SERVICE with `pending=4'b1010` → all outputs 0 in the same cycle, asynchronously. After release, no request until a new rise.
- Build with `EXT_IRQ_SYNC_EN` and pulse line 1 → `pending[1]` set after edge k+2, `irq_req` after edge k+3.
